// File: rtl/mult_booth_seq.sv
// Sequential 32x32 signed multiplier using radix-4 modified Booth recoding.
// It runs 16 iterations, one per clock, and presents a start/ready handshake.
// The accumulator is 34 bits wide so that the +/-2M term for -2^31 fits.
module mult_booth_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [33:0] r_a;
  logic [33:0] r_m;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [3:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;
  logic        r_busy;

  logic [33:0] w_addend;
  logic        w_cin;
  logic [33:0] w_a_sum;
  logic [33:0] w_a_sh;
  logic [31:0] w_q_sh;
  logic [32:0] w_hi;
  logic        w_ovf;
  logic        w_accept;

  // Booth recoder: the negative terms are the inverted value plus a carry-in
  always_comb begin
    w_addend = 34'd0;
    w_cin    = 1'b0;
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = r_m;
      3'b011:         w_addend = {r_m[32:0], 1'b0};
      3'b100: begin
        w_addend = ~{r_m[32:0], 1'b0};
        w_cin    = 1'b1;
      end
      3'b101, 3'b110: begin
        w_addend = ~r_m;
        w_cin    = 1'b1;
      end
      default: begin
        w_addend = 34'd0;
        w_cin    = 1'b0;
      end
    endcase
  end

  // Accumulate, then arithmetic-shift {A', Q, q_-1} right by two
  always_comb begin
    w_a_sum = r_a + w_addend + {33'd0, w_cin};
    w_a_sh  = {{2{w_a_sum[33]}}, w_a_sum[33:2]};
    w_q_sh  = {w_a_sum[1:0], r_q[31:2]};
    // Product bits [63:31] of the final iteration; they must all agree for no overflow
    w_hi    = {w_a_sh[31:0], w_q_sh[31]};
    w_ovf   = !((&w_hi) || (~|w_hi));
  end

  assign w_accept = ctrl_MULT && (r_state != S_RUN);

  // Control FSM and datapath; the result registers change only when entering DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= 34'd0;
      r_m      <= 34'd0;
      r_q      <= 32'd0;
      r_qm1    <= 1'b0;
      r_cnt    <= 4'd0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_a   <= w_a_sh;
          r_q   <= w_q_sh;
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state  <= S_DONE;
            r_result <= w_q_sh;
            r_exc    <= w_ovf;
            r_rdy    <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_m     <= {{2{data_operandA[31]}}, data_operandA};
            r_q     <= data_operandB;
            r_qm1   <= 1'b0;
            r_a     <= 34'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed and random checks for mult_booth_seq: products, overflow flag,
// handshake timing, start-while-busy, back-to-back and reset abort.
module tb_mult_booth_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[14];

  mult_booth_seq dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands and a one-cycle start pulse; operands are scrambled after the accepting edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Count negedges after the start edge until ready; bounded
  task automatic wait_rdy(output int cyc);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      cyc++;
      if (data_resultRDY) break;
    end
    if (!data_resultRDY) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: no data_resultRDY after %0d cycles", cyc);
    end
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc, input bit timing);
    int cyc;
    start_op(a, b);
    wait_rdy(cyc);
    if (timing) chk({name, "_latency"}, cyc, 32'd17);
    chk({name, "_result"}, data_result, res);
    chk({name, "_exc"}, {31'd0, data_exception}, {31'd0, exc});
    if (timing) begin
      @(negedge clock);
      chk({name, "_rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({name, "_result_held"}, data_result, res);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    logic signed [63:0] p;
    logic [31:0] specials [6];

    vecs[0]  = '{32'd3,        32'd4,        32'd12,         1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6,   1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,          1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE,   1'b1};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1'b1};
    vecs[5]  = '{32'h80000000, 32'd1,        32'h80000000,   1'b0};
    vecs[6]  = '{32'd0,        32'h12345678, 32'd0,          1'b0};
    vecs[7]  = '{32'h80000000, 32'h80000000, 32'd0,          1'b1};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,          1'b1};
    vecs[9]  = '{32'hFFFFFFFD, 32'd100,      32'hFFFFFED4,   1'b0};
    vecs[10] = '{32'h00010000, 32'h00010000, 32'd0,          1'b1};
    vecs[11] = '{32'h00010000, 32'h00008000, 32'h80000000,   1'b1};
    vecs[12] = '{32'hFFFF0000, 32'h00008000, 32'h80000000,   1'b0};
    vecs[13] = '{32'd1000,     32'hFFFFFC18, 32'hFFF0BDC0,   1'b0};

    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h7FFFFFFF;
    specials[4] = 32'h80000000;
    specials[5] = 32'h00010000;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, 1'b1);

    // Start pulse at cycle 8 of a running op is ignored
    start_op(32'd5, 32'd5);
    chk("busy_running", {31'd0, busy}, 32'd1);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      cyc++;
      if (data_resultRDY) break;
      if (cyc == 8) begin
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
      end
    end
    chk("busy_ign_latency", cyc, 32'd17);
    chk("busy_ign_result", data_result, 32'd25);

    // Start during the DONE cycle: back-to-back
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    chk("b2b_busy_kept", {31'd0, busy}, 32'd1);
    chk("b2b_old_result_held", data_result, 32'd25);
    wait_rdy(cyc);
    chk("b2b_latency", cyc, 32'd17);
    chk("b2b_result", data_result, 32'd81);
    @(negedge clock);
    chk("b2b_single_pulse", {31'd0, data_resultRDY}, 32'd0);

    // Reset in the middle of an operation
    start_op(32'd123, 32'd456);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_result", data_result, 32'd0);
    chk("rst_mid_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (data_resultRDY || busy) cyc++;
    end
    chk("rst_no_activity", cyc, 32'd0);
    run_check("post_rst", 32'hFFFFFFFD, 32'd100, 32'hFFFFFED4, 1'b0, 1'b1);

    // Random regression against a 64-bit signed product
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_check($sformatf("rnd%0d", i), ra, rb, p[31:0],
                !((&p[63:31]) || (~|p[63:31])), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
